// File: rtl/jtpopeye_rom_arb.sv
// rtl/jtpopeye_rom_arb.sv - round-robin arbiter sharing one SDRAM ROM read port among four cached slots
module jtpopeye_rom_arb #(
    parameter int AW      = 22,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            downloading,
    input  logic            loop_rst,
    input  logic [3:0]      slot_cs,
    input  logic [4*AW-1:0] slot_addr,
    output logic [3:0]      slot_ok,
    output logic [4*DW-1:0] slot_dout,
    output logic [AW-1:0]   sdram_addr,
    output logic            sdram_re,
    input  logic [DW-1:0]   data_read,
    input  logic            data_rdy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state, state_nx;
    logic [3:0]    valid;
    logic [AW-1:0] caddr [4];
    logic [1:0]    rr, gnt, pick, idx;
    logic          found;
    logic [7:0]    tcnt;
    logic [3:0]    hit, pending;
    logic          hold, grant, fill;

    assign hold = downloading | loop_rst;

    always_comb begin
        hit     = 4'd0;
        slot_ok = 4'd0;
        pending = 4'd0;
        for (int i = 0; i < 4; i++) begin
            hit[i]     = valid[i] && (caddr[i] == slot_addr[i*AW +: AW]);
            slot_ok[i] = slot_cs[i] & hit[i];
            pending[i] = slot_cs[i] & ~hit[i];
        end
    end

    // Search starts just after the last granted slot, so that slot is tried last.
    always_comb begin
        found = 1'b0;
        pick  = rr;
        idx   = rr;
        for (int k = 1; k <= 4; k++) begin
            idx = rr + 2'(k);
            if (!found && pending[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT: begin
                if (data_rdy)
                    state_nx = IDLE;
                else if (tcnt == 8'(TIMEOUT - 1))
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (hold) state_nx = IDLE;
    end

    assign sdram_re = (state == ISSUE) && !hold;
    assign grant    = (state == IDLE) && found && !hold;
    assign fill     = (state == WAIT) && data_rdy && !hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            valid      <= 4'd0;
            rr         <= 2'd3;
            gnt        <= 2'd0;
            tcnt       <= 8'd0;
            sdram_addr <= '0;
            slot_dout  <= '0;
            for (int i = 0; i < 4; i++) caddr[i] <= '0;
        end else begin
            state <= state_nx;
            if (grant) begin
                gnt        <= pick;
                rr         <= pick;
                sdram_addr <= slot_addr[int'(pick)*AW +: AW];
            end
            if (state == ISSUE)
                tcnt <= 8'd0;
            else if (state == WAIT)
                tcnt <= tcnt + 8'd1;
            // ROM contents may change under download/refresh reset, so drop every cache line.
            if (hold) begin
                valid <= 4'd0;
            end else if (fill) begin
                valid[gnt]                   <= 1'b1;
                caddr[gnt]                   <= sdram_addr;
                slot_dout[int'(gnt)*DW +: DW] <= data_read;
            end
        end
    end

endmodule

// File: doc/jtpopeye_rom_arb.md
Name: jtpopeye_rom_arb

Overview:
- Shares the single SDRAM ROM read port (sdram_addr / sdram_re / data_read) among four game-side ROM requesters: main CPU, character ROM, object ROM and spare.
- Sits between jtpopeye_game's internal ROM clients and the jtframe SDRAM controller.
- Arbitration is round-robin.
- Each slot keeps a one-entry 32-bit cache, so repeated reads of the same address cost no SDRAM cycle.

Parameters:
- AW, 22, SDRAM word address width.
- DW, 32, SDRAM read data width.
- TIMEOUT, 255, max cycles waited in WAIT for data_rdy before abandoning the access. 8-bit counter.

Ports:
- clk  in  1  system clock, same as game clk_rgb (20 MHz).
- rst_n  in  1  reset, asynchronous, active-low.
- downloading  in  1  ROM download in progress. Arbiter held idle.
- loop_rst  in  1  SDRAM controller init/refresh reset. Arbiter held idle.
- slot_cs  in  4  per-slot read request, level.
- slot_addr  in  4*AW  per-slot word address. Slot i occupies bits [i*AW +: AW].
- slot_ok  out  4  per-slot data valid for current slot_addr.
- slot_dout  out  4*DW  per-slot cached data. Slot i occupies bits [i*DW +: DW].
- sdram_addr  out  AW  address to SDRAM controller.
- sdram_re  out  1  one-cycle read strobe.
- data_read  in  DW  SDRAM read data.
- data_rdy  in  1  one-cycle pulse, data_read valid.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - sdram_re=0, sdram_addr=0, slot_dout=0, slot_ok=0.
  - All cache valid bits=0, cache addresses=0.
  - Round-robin pointer=3, so slot 0 wins first.
  - State=IDLE, timeout counter=0.
- Per-slot cache: valid[i], caddr[i] (AW bits), slot_dout[i].
- hit[i] = valid[i] & caddr[i]==slot_addr[i], combinational from registers.
- slot_ok[i] = slot_cs[i] & hit[i], combinational. It drops the same cycle slot_addr changes to a non-matching value.
- pending[i] = slot_cs[i] & ~hit[i].
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If pending≠0, grant the first pending slot searching upward from rr+1, modulo 4.
  - Latch gnt, latch sdram_addr<=slot_addr[gnt], set rr<=gnt, go ISSUE.
  - If pending=0, stay in IDLE.
- ISSUE:
  - sdram_re=1 for exactly this cycle, sdram_addr held.
  - Clear timeout counter, go WAIT.
- WAIT:
  - On data_rdy: slot_dout[gnt]<=data_read, caddr[gnt]<=latched address, valid[gnt]<=1, go IDLE.
  - Otherwise the counter increments. At TIMEOUT the access is abandoned: go IDLE with no cache update. rr already points at gnt, so other slots get priority next.
- Latency:
  - Hit: slot_ok in the same cycle as slot_cs/addr.
  - Miss with idle arbiter, request seen in cycle N: sdram_re in N+1, data_rdy in cycle K>N+1, slot_ok from K+1.
- Request changes after grant:
  - Grant is latched. Later changes to slot_addr or slot_cs of the granted slot do not abort the access.
  - Returned data is stored against the latched address. If the slot's address has changed, it then misses and re-requests.
- Withdrawal: a slot whose cs drops before being granted is simply not selected.
- Idle conditions (downloading=1 or loop_rst=1), any state:
  - Next cycle state=IDLE, sdram_re=0.
  - All valid bits cleared, which invalidates caches since ROM contents may change.
  - No grants issued while either is high.
  - A data_rdy arriving during this time is ignored.
- Data with no access: data_rdy in IDLE or ISSUE is ignored.
- Simultaneous events: if data_rdy and downloading rise in the same cycle, downloading wins and no cache write occurs.
- Starvation bound: worst-case wait for a pending slot is 3 other accesses.
- sdram_addr holds its last value between accesses.

Test Plan:
- Reset, then slot_cs=4'b0001, slot0 addr=0x00100, data_rdy 3 cycles after sdram_re with data 0xDEADBEEF -> one sdram_re pulse with sdram_addr=0x00100; slot_ok[0]=1 and slot_dout[0]=0xDEADBEEF the cycle after data_rdy.
- Continue the previous case: hold slot0 addr 0x00100 for 20 cycles -> no further sdram_re; slot_ok[0] stays 1. Change addr to 0x00101 -> slot_ok[0] drops the same cycle, and a new sdram_re occurs 1 cycle later.
- Requests: slot_cs=4'b1111, all different addrs, data_rdy 2 cycles after each sdram_re -> grants in order 0,1,2,3. Then invalidate slot 1 and slot 3 by changing their addresses -> next grants 1 then 3, never 1 twice in a row while 3 is pending.
- Data never returned: sdram_re issued, no data_rdy -> FSM returns to IDLE after 255 WAIT cycles; slot_ok stays 0; the next pending slot is granted.
- Download mid-access: assert downloading while in WAIT, then pulse data_rdy -> no cache write, all slot_ok=0, no sdram_re while downloading=1. Release downloading -> previously cached addresses re-fetched.
- Reset mid-access: assert rst_n=0 during WAIT -> sdram_re=0, slot_ok=0, slot_dout=0 immediately (asynchronous). After release, the first grant goes to slot 0.
